// File: rtl/dma_trig_pkg.sv
// Shared types and defaults for the DMA trigger scheduler.
package dma_trig_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2
  } sched_state_e;

  // Default number of WAIT cycles before a transfer is declared hung.
  localparam int DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/trig_capture.sv
// Per-channel trigger capture: rising-edge detect, pending latch and sticky overrun.
module trig_capture (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  input  logic clr_i,        // scheduler is granting this channel this cycle
  input  logic err_clear_i,
  output logic pending_o,
  output logic overrun_o
);

  logic trig_d_q;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic rise;

  assign rise = trig_i & ~trig_d_q;

  // Next-state for pending/overrun: a fresh edge beats both the grant clear and err_clear.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clr_i)       pending_d = 1'b0;
    if (rise)        pending_d = 1'b1;
    if (err_clear_i) overrun_d = 1'b0;
    if (rise && pending_q) overrun_d = 1'b1;
  end

  // Registers; trig_d resets low so a level already high at reset release is an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_d_q  <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      trig_d_q  <= trig_i;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/dma_trigger_sched.sv
// Round-robin scheduler of trigger sources onto a single DMA engine.
// Optional WAIT timeout enabled by defining DMA_TIMEOUT_EN.
// Handshake: dma_start is a one-cycle pulse with dma_ch valid; dma_ch holds until
// dma_done (one-cycle pulse, honoured only in WAIT) returns the FSM to IDLE.
module dma_trigger_sched
  import dma_trig_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trig_in,
  output logic              dma_start,
  output logic [CH_W-1:0]   dma_ch,
  input  logic              dma_done,
  output logic              busy,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  output logic              err_timeout,
  input  logic              err_clear,
  output logic [1:0]        dbg_state_o
);

  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   dma_ch_q, dma_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              dma_start_q;
  logic [CH_W-1:0]   sel_ch;
  logic              enter_issue;
  logic              timeout_hit;
  logic              timeout_fire;
  logic [NUM_CH-1:0] clr_vec;
  int                idx;

  // Per-channel capture cells; the grant clears the selected channel on entry to ISSUE.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cap
    assign clr_vec[g] = enter_issue && (sel_ch == CH_W'(g));
    trig_capture u_cap (
      .clk         (clk),
      .rst         (rst),
      .trig_i      (trig_in[g]),
      .clr_i       (clr_vec[g]),
      .err_clear_i (err_clear),
      .pending_o   (pending[g]),
      .overrun_o   (overrun[g])
    );
  end

  // Round-robin pick: first pending channel above last_grant, wrapping around.
  always_comb begin
    sel_ch = '0;
    idx    = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (pending[idx]) sel_ch = CH_W'(idx);
    end
  end

  // FSM next-state and grant bookkeeping.
  always_comb begin
    state_d      = state_q;
    dma_ch_d     = dma_ch_q;
    last_grant_d = last_grant_q;
    enter_issue  = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        if (|pending) begin
          state_d     = SCHED_ISSUE;
          dma_ch_d    = sel_ch;
          enter_issue = 1'b1;
        end
      end
      SCHED_ISSUE: begin
        state_d      = SCHED_WAIT;
        last_grant_d = dma_ch_q;
      end
      SCHED_WAIT: begin
        if (dma_done) begin
          state_d = SCHED_IDLE;
        end else if (timeout_hit) begin
          state_d      = SCHED_IDLE;
          timeout_fire = 1'b1;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // FSM state, grant channel and registered start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCHED_IDLE;
      dma_ch_q     <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      dma_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dma_ch_q     <= dma_ch_d;
      last_grant_q <= last_grant_d;
      dma_start_q  <= (state_d == SCHED_ISSUE);
    end
  end

`ifdef DMA_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            err_timeout_q;

  assign timeout_hit = (state_q == SCHED_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // WAIT cycle counter, restarted as the FSM passes through ISSUE.
  always_ff @(posedge clk) begin
    if (rst)                          to_cnt_q <= '0;
    else if (state_q == SCHED_ISSUE)  to_cnt_q <= '0;
    else if (state_q == SCHED_WAIT)   to_cnt_q <= to_cnt_q + 1'b1;
  end

  // Sticky timeout flag; a firing timeout beats a simultaneous err_clear.
  always_ff @(posedge clk) begin
    if (rst)               err_timeout_q <= 1'b0;
    else if (timeout_fire) err_timeout_q <= 1'b1;
    else if (err_clear)    err_timeout_q <= 1'b0;
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0) | timeout_fire;
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  assign dma_start   = dma_start_q;
  assign dma_ch      = dma_ch_q;
  assign busy        = (state_q == SCHED_ISSUE) || (state_q == SCHED_WAIT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_trigger_sched.sv
// Bench for dma_trigger_sched: directed scenarios then randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_dma_trigger_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int TO_CYC = 16;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] trig_in = '0;
  logic              dma_done = 1'b0;
  logic              err_clear = 1'b0;
  logic              dma_start;
  logic [CH_W-1:0]   dma_ch;
  logic              busy;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;
  logic              err_timeout;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  dma_trigger_sched #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig_in     (trig_in),
    .dma_start   (dma_start),
    .dma_ch      (dma_ch),
    .dma_done    (dma_done),
    .busy        (busy),
    .pending     (pending),
    .overrun     (overrun),
    .err_timeout (err_timeout),
    .err_clear   (err_clear),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a channel is "in service" from grant until done/timeout;
  // the first cycle of service is the start cycle.
  logic [NUM_CH-1:0] m_pend, m_ovr, m_trig_d;
  int                m_last, m_ch, m_wait;
  bit                m_in, m_start, m_err;
  logic [CH_W-1:0]   exp_q[$];

  function automatic int rr_pick(input logic [NUM_CH-1:0] p, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (p[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_trig_d = '0;
    m_last = NUM_CH - 1; m_ch = 0; m_wait = 0;
    m_in = 0; m_start = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] rise, grant_mask;
    bit                set_err;
    int                c;
    if (rst) begin
      model_reset();
      return;
    end
    rise       = trig_in & ~m_trig_d;
    grant_mask = '0;
    set_err    = 0;
    if (!m_in && m_pend != 0) begin
      c = rr_pick(m_pend, m_last);
      m_ch = c; grant_mask[c] = 1'b1;
      m_in = 1; m_start = 1;
      exp_q.push_back(CH_W'(c));
    end else if (m_start) begin
      m_start = 0; m_last = m_ch; m_wait = 0;
    end else if (m_in) begin
      if (dma_done) m_in = 0;
`ifdef DMA_TIMEOUT_EN
      else if (m_wait == TO_CYC - 1) begin m_in = 0; set_err = 1; end
      else m_wait++;
`endif
    end
    m_ovr    = (err_clear ? '0 : m_ovr) | (rise & m_pend);
    m_pend   = (m_pend & ~grant_mask) | rise;
    m_err    = set_err | (m_err & ~err_clear);
    m_trig_d = trig_in;
  endtask

  // ---------------- driver / responder ----------------
  int resp_cnt   = -1;
  int resp_delay = 5;   // 0 means never answer

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("start", dma_start, m_start);
    check_eq("busy", busy, m_in);
    check_eq("pending", pending, m_pend);
    check_eq("overrun", overrun, m_ovr);
    check_eq("err_timeout", err_timeout, m_err);
    if (m_in) check_eq("dma_ch", dma_ch, m_ch);
    if (dma_start) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected_start", 1, 0);
      else check_eq("sb_grant", dma_ch, exp_q.pop_front());
      if (resp_delay > 0) resp_cnt = resp_delay;
    end
    dma_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin dma_done = 1'b1; resp_cnt = -1; end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; resp_cnt = -1;
    run(n);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset(2);
    check_eq("reset_dma_ch", dma_ch, 0);
    check_eq("reset_state", dbg_state, 0);

    // single request on channel 2
    trig_in = 4'b0100; run(12); trig_in = '0; run(2);

    // all four at once, then fresh edges on 1 and 3
    resp_delay = 5;
    trig_in = 4'b1111; run(30);
    trig_in = 4'b0000; tick();
    trig_in = 4'b1010; run(20);
    trig_in = 4'b0000; run(2);

    // coalesce: toggle ch1 twice while ch0 is in service
    resp_delay = 8;
    trig_in = 4'b0001; run(2);
    trig_in = 4'b0011; tick();
    trig_in = 4'b0001; tick();
    trig_in = 4'b0011; tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    trig_in = 4'b0000; run(25);

    // re-trigger channel 0 during its own service
    trig_in = 4'b0001; run(4);
    trig_in = 4'b0000; tick();
    trig_in = 4'b0001; tick();
    trig_in = 4'b0000; run(25);

    // reset in the middle of WAIT
    trig_in = 4'b0100; run(4);
    trig_in = 4'b0000; do_reset(1);
    check_eq("midwait_reset_busy", busy, 0);
    run(10);

`ifdef DMA_TIMEOUT_EN
    // no completion: timeout must fire
    resp_delay = 0;
    trig_in = 4'b1000; run(24);
    trig_in = 4'b0000;
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    run(3);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 5) == 0) trig_in[c] = ~trig_in[c];
      err_clear  = ($urandom_range(0, 40) == 0);
`ifdef DMA_TIMEOUT_EN
      resp_delay = ($urandom_range(0, 30) == 0) ? 0 : int'($urandom_range(2, 8));
`else
      resp_delay = $urandom_range(2, 8);
`endif
      if ($urandom_range(0, 400) == 0) do_reset(1);
      else tick();
    end

    // drain: every granted request must have started and the engine idles
    trig_in = '0; err_clear = 1'b0; resp_delay = 3;
    run(60);
    check_eq("drain_queue_empty", exp_q.size(), 0);
    check_eq("drain_idle", busy, 0);
    check_eq("drain_pending", pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dma_trigger_sched.md
# dma_trigger_sched

Schedules DMA transfers from several independent trigger sources onto one shared AXI DMA (PL→DDR) engine. Each trigger input is rising-edge detected, and the edge is latched as a pending request. Pending requests are granted round-robin, one at a time. For each grant the block issues a single-cycle start pulse and channel index to the DMA controller, then holds off further grants until the controller reports completion.

## Interface
Parameters:
- NUM_CH, 4: number of trigger sources (2..16).
- CH_W, $clog2(NUM_CH): width of the channel index.
- TIMEOUT_CYC, 65535: maximum cycles to wait for dma_done. Used only when DMA_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- trig_in  in  NUM_CH  level trigger per source; a rising edge requests one transfer.
- dma_start  out  1  one-cycle start pulse to the DMA controller.
- dma_ch  out  CH_W  granted channel; valid while dma_start is high and held stable through WAIT.
- dma_done  in  1  one-cycle completion pulse from the DMA controller.
- busy  out  1  high in ISSUE and WAIT.
- pending  out  NUM_CH  latched, not-yet-issued requests.
- overrun  out  NUM_CH  sticky; an edge arrived while that channel's pending bit was already set.
- err_timeout  out  1  sticky timeout flag; constant 0 without DMA_TIMEOUT_EN.
- err_clear  in  1  clears overrun and err_timeout.

## Operation
- Edge capture per channel: rise[i] = trig_in[i] & ~trig_d[i]. trig_d resets to 0, so a trig_in already high when reset releases counts as an edge.
- Pending update per channel:
  - rise[i] sets pending[i].
  - Entering ISSUE clears pending[dma_ch].
  - If rise and clear hit the same bit in the same cycle, set wins. The new edge is served in a later round.
- Overrun: rise[i] while pending[i]=1 sets overrun[i]. The request is coalesced, not queued.
- err_clear: clears overrun and err_timeout in the next cycle. A new overrun in the same cycle as err_clear wins.
- FSM states:
  - IDLE: if pending≠0, select the first set bit searching upward from last_grant+1 with wrap-around. Register it into dma_ch and go to ISSUE.
  - ISSUE: dma_start=1 for exactly one cycle; clear the pending bit; last_grant←dma_ch; go to WAIT.
  - WAIT: dma_done=1 → IDLE. With DMA_TIMEOUT_EN, reaching TIMEOUT_CYC cycles in WAIT → set err_timeout and go to IDLE.
- dma_done outside WAIT is ignored.
- Reset values:
  - state=IDLE.
  - dma_start=0, dma_ch=0, busy=0.
  - pending=0, overrun=0, err_timeout=0.
  - trig_d=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
  - Timeout counter=0.
- Reset asserted mid-transfer (ISSUE or WAIT) aborts immediately to the reset state. Outstanding requests are discarded.

## Timing
- Trigger to start latency is 2 cycles:
  - trig_in rises before edge k → pending[i]=1 after edge k.
  - state=ISSUE after edge k+1.
  - dma_start high between edges k+1 and k+2.
- dma_start is registered and never high on two consecutive cycles.
- Back-to-back grants:
  - dma_done in cycle m → IDLE after edge m.
  - Next dma_start at the earliest after edge m+1.
  - Minimum start-to-start spacing is 3 cycles.
- dma_ch changes only on entry to ISSUE.
- Timeout counter:
  - Cleared on entry to WAIT; increments each WAIT cycle.
  - Fires when the count equals TIMEOUT_CYC-1.
  - dma_done in the firing cycle counts as completion and does not set the error.

## Configuration
- DMA_TIMEOUT_EN defined: WAIT timeout counter present, and err_timeout is live as described above.
- Not defined: no counter logic, err_timeout tied to 0, and WAIT exits only on dma_done.

## Structure
- Package dma_trig_pkg:
  - State enum: SCHED_IDLE, SCHED_ISSUE, SCHED_WAIT.
  - Default TIMEOUT_CYC constant.
- Sub-module trig_capture holds the per-channel trig_d register, rise detect, pending bit and overrun bit. It is instantiated NUM_CH times via generate.
- Round-robin select and the FSM live in the top module.

## Test plan
- Single request: rst low, pulse trig_in[2] 0→1 → dma_start one cycle, 2 cycles after the edge, with dma_ch=2; busy stays high until dma_done, then pending=0.
- Round-robin fairness: trig_in[0..3] all rise in the same cycle, with dma_done returned 5 cycles after each start → grant order is 0,1,2,3; after fresh edges on 1 and 3, next order is 1,3.
- Coalesce/overrun: trig_in[1] toggles twice while pending[1]=1 → one transfer only, overrun[1]=1; err_clear → overrun=0 next cycle.
- Re-trigger during service: edge on ch 0 during its own WAIT → pending[0]=1, and a second start on ch 0 is issued after dma_done.
- Timeout, with DMA_TIMEOUT_EN and TIMEOUT_CYC=16: dma_done never asserted → err_timeout=1 after 16 WAIT cycles and FSM in IDLE. Without the macro: busy stays high indefinitely.
- Reset mid-WAIT: rst for 1 cycle → all outputs at reset values next cycle; no dma_start until a new edge arrives.
